// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
//   mem_state_e : data-memory wait FSM states (IDLE, WAIT, ERR)
//   FWD_*       : E-stage operand forward select encodings
//   RESULT_SRC_LOAD : ResultSrcE value that marks a load in E
//   fwd_sel()   : forward select for one E-stage source register
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // M-stage result is younger than W-stage, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m,
                                         input logic       we_m,
                                         input logic [4:0] rd_w,
                                         input logic       we_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return FWD_M;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait tracker: follows an M-stage access that is not acked in its
// first cycle, raises a stall while it waits, and latches a terminal error after
// TIMEOUT unacked wait cycles.
// Ports:
//   CLK, RST     : clock, synchronous active-high reset
//   MemReqM      : M-stage load/store valid
//   MemAckM      : memory ready (data in the same cycle)
//   MemStall     : combinational stall request for the whole pipeline
//   MemBusy      : registered, access outstanding (WAIT state)
//   MemTimeout   : registered, access timed out (ERR state, cleared only by RST)
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic MemReqM,
  input  logic MemAckM,
  output logic MemStall,
  output logic MemBusy,
  output logic MemTimeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LastWait = CW'(TIMEOUT - 1);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    MemStall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A same-cycle ack completes the access with no stall at all.
        if (MemReqM && !MemAckM) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
          MemStall   = 1'b1;
        end
      end
      WAIT: begin
        if (MemAckM) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          MemStall   = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == LastWait) begin
            state_d = ERR;
          end
        end
      end
      ERR: begin
        MemStall = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign MemBusy    = (state_q == WAIT);
  assign MemTimeout = (state_q == ERR);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: E-stage operand forwarding, load-use stall,
// branch flush and data-memory wait stalls, plus a saturating stall counter.
// Ports:
//   CLK, RST                    : clock, synchronous active-high reset
//   Rs1D/Rs2D, Rs1E/Rs2E        : source registers in D and E
//   RdE/RdM/RdW                 : destination registers in E, M, W
//   RegWriteM/RegWriteW         : register-file write enables in M, W
//   ResultSrcE                  : E result select (load = RESULT_SRC_LOAD)
//   PCSrcE                      : taken branch/jump resolved in E
//   MemReqM/MemAckM             : M-stage memory request / ready
//   StallF/D/E/M, FlushD/E/W    : pipeline register hold / bubble controls
//   ForwardAE/ForwardBE         : E operand forward selects
//   MemBusy/MemTimeout          : registered memory wait / error status
//   StallCnt                    : count of memory-stall cycles, saturating
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNTW    = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      Rs1E,
  input  logic [4:0]      Rs2E,
  input  logic [4:0]      RdE,
  input  logic [4:0]      RdM,
  input  logic [4:0]      RdW,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcE,
  input  logic            PCSrcE,
  input  logic            MemReqM,
  input  logic            MemAckM,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushD,
  output logic            FlushE,
  output logic            FlushW,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            MemBusy,
  output logic            MemTimeout,
  output logic [CNTW-1:0] StallCnt
);

  logic            mem_stall;
  logic            load_stall;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  mem_wait_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_wait_fsm (
    .CLK        (CLK),
    .RST        (RST),
    .MemReqM    (MemReqM),
    .MemAckM    (MemAckM),
    .MemStall   (mem_stall),
    .MemBusy    (MemBusy),
    .MemTimeout (MemTimeout)
  );

  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  assign load_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      // Freeze everything; a pending branch flush is held back until release
      // so the redirect is not lost while E is frozen.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = load_stall;
      StallD = load_stall;
      FlushD = PCSrcE;
      FlushE = PCSrcE || load_stall;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;

endmodule
